arm_ctrl_fsm: RTL and testbench

Multi-cycle control unit for the ARM-subset CPU.
- Decodes the latched instruction word I into register addresses and immediate fields.
- Sequences FETCH/DECODE/EXEC/WB states, driving the fetch unit, the register file, the A/B/C/F/NZCV latches, and the barrel-shifter and ALU operand muxes.
- Supported: data-processing (all 16 opcodes, immediate/imm-shift/reg-shift operand 2), B and BL. Everything else is reported as undefined.

---
 rtl/arm_ctrl_pkg.sv | 64 ++++++
 rtl/arm_ctrl_decode.sv | 75 +++++++
 rtl/arm_ctrl_fsm.sv | 197 +++++++++++++++++++
 tb/tb_arm_ctrl_fsm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arm_ctrl_pkg                                                         |
// | Shared encodings for the ARM-subset multi-cycle control unit.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package arm_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    LINK   = 3'd4,
    LWB    = 3'd5,
    BEXEC  = 3'd6,
    BWB    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_UND = 2'd0,
    CLS_DP  = 2'd1,
    CLS_B   = 2'd2,
    CLS_BL  = 2'd3
  } ins_class_t;

  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_EOR = 4'b0001;
  localparam logic [3:0] c_ALU_SUB = 4'b0010;
  localparam logic [3:0] c_ALU_RSB = 4'b0011;
  localparam logic [3:0] c_ALU_ADD = 4'b0100;
  localparam logic [3:0] c_ALU_ADC = 4'b0101;
  localparam logic [3:0] c_ALU_SBC = 4'b0110;
  localparam logic [3:0] c_ALU_RSC = 4'b0111;
  localparam logic [3:0] c_ALU_TST = 4'b1000;
  localparam logic [3:0] c_ALU_TEQ = 4'b1001;
  localparam logic [3:0] c_ALU_CMP = 4'b1010;
  localparam logic [3:0] c_ALU_CMN = 4'b1011;
  localparam logic [3:0] c_ALU_ORR = 4'b1100;
  localparam logic [3:0] c_ALU_MOV = 4'b1101;
  localparam logic [3:0] c_ALU_BIC = 4'b1110;
  localparam logic [3:0] c_ALU_MVN = 4'b1111;

  localparam logic [2:0] c_SHIFT_LSL = 3'b000;
  localparam logic [2:0] c_SHIFT_LSR = 3'b010;
  localparam logic [2:0] c_SHIFT_ASR = 3'b100;
  localparam logic [2:0] c_SHIFT_ROR = 3'b110;

  localparam logic [1:0] c_PC_S_PC4 = 2'b00;
  localparam logic [1:0] c_PC_S_F   = 2'b10;

  localparam logic [1:0] c_RS_IMM5 = 2'b00;
  localparam logic [1:0] c_RS_REG  = 2'b01;
  localparam logic [1:0] c_RS_ROT  = 2'b10;

  localparam logic [3:0] c_LINK_REG = 4'd15;

  // TST/TEQ/CMP/CMN only produce flags and never write a destination.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arm_ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arm_ctrl_decode                                                      |
// | Combinational instruction classifier, field and operand-2 decode.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arm_ctrl_decode
  import arm_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic        i_force_link_rm,
  input  logic        i_zero_imm5,
  output logic [3:0]  o_rd,
  output logic [3:0]  o_rn,
  output logic [3:0]  o_rm,
  output logic [3:0]  o_rs,
  output logic [4:0]  o_imm5,
  output logic [11:0] o_imm12,
  output logic [23:0] o_imm24,
  output ins_class_t  o_class,
  output logic [3:0]  o_opcode,
  output logic        o_set_flags,
  output logic        o_rm_imm_s,
  output logic [1:0]  o_rs_imm_s,
  output logic [2:0]  o_shift_op
);

  logic w_is_dp;
  logic w_is_branch;
  logic w_unused_cond;

  // The condition field is ignored: every instruction executes.
  assign w_unused_cond = ^i_instr[31:28];

  assign o_rd    = i_instr[15:12];
  assign o_rn    = i_instr[19:16];
  assign o_rs    = i_instr[11:8];
  assign o_imm12 = i_instr[11:0];
  assign o_imm24 = i_instr[23:0];
  assign o_rm    = i_force_link_rm ? c_LINK_REG : i_instr[3:0];
  assign o_imm5  = i_zero_imm5 ? 5'd0 : i_instr[11:7];

  // Register-shift encodings with bit7 set are the multiply/extension space.
  assign w_is_dp     = (i_instr[27:26] == 2'b00) &&
                       !(!i_instr[25] && i_instr[7] && i_instr[4]);
  assign w_is_branch = (i_instr[27:25] == 3'b101);

  always_comb begin
    o_class = CLS_UND;
    if (w_is_dp) begin
      o_class = CLS_DP;
    end else if (w_is_branch) begin
      o_class = i_instr[24] ? CLS_BL : CLS_B;
    end
  end

  assign o_opcode    = i_instr[24:21];
  assign o_set_flags = i_instr[20] | is_test_op(i_instr[24:21]);

  always_comb begin
    o_rm_imm_s = 1'b0;
    o_rs_imm_s = c_RS_IMM5;
    o_shift_op = c_SHIFT_LSL;
    if (i_instr[25]) begin
      o_rm_imm_s = 1'b1;
      o_rs_imm_s = c_RS_ROT;
      o_shift_op = c_SHIFT_ROR;
    end else begin
      o_shift_op = {i_instr[6:5], i_instr[4]};
      o_rs_imm_s = i_instr[4] ? c_RS_REG : c_RS_IMM5;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arm_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arm_ctrl_fsm                                                         |
// | Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the ARM-subset CPU.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arm_ctrl_fsm
  import arm_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] I,
  input  logic [31:0] IR_buf,
  input  logic        W_IR_valid,
  output logic [3:0]  rd,
  output logic [3:0]  rn,
  output logic [3:0]  rm,
  output logic [3:0]  rs,
  output logic [4:0]  imm5,
  output logic [11:0] imm12,
  output logic [23:0] imm24,
  output logic        Und_Ins,
  output logic        write_pc,
  output logic        write_ir,
  output logic        write_reg,
  output logic        LA,
  output logic        LB,
  output logic        LC,
  output logic        LF,
  output logic [1:0]  pc_s,
  output logic        ALU_A_s,
  output logic        ALU_B_s,
  output logic        rd_s,
  output logic        S_ctrl,
  output logic        rm_imm_s_ctrl,
  output logic [1:0]  rs_imm_s_ctrl,
  output logic [2:0]  Shift_OP_ctrl,
  output logic [3:0]  ALU_OP_ctrl
);

  state_t     r_state;
  state_t     w_next_state;
  ins_class_t w_class;
  logic [3:0] w_opcode;
  logic       w_set_flags;
  logic       w_rm_imm_s;
  logic [1:0] w_rs_imm_s;
  logic [2:0] w_shift_op;
  logic       w_force_link_rm;
  logic       w_zero_imm5;
  logic       w_unused_ir_buf;

  assign w_unused_ir_buf = ^IR_buf;

  // BL reads R15 into B during DECODE; LINK moves it through an LSL #0.
  assign w_force_link_rm = (r_state == DECODE) && (w_class == CLS_BL);
  assign w_zero_imm5     = (r_state == LINK);

  arm_ctrl_decode u_decode (
    .i_instr         (I),
    .i_force_link_rm (w_force_link_rm),
    .i_zero_imm5     (w_zero_imm5),
    .o_rd            (rd),
    .o_rn            (rn),
    .o_rm            (rm),
    .o_rs            (rs),
    .o_imm5          (imm5),
    .o_imm12         (imm12),
    .o_imm24         (imm24),
    .o_class         (w_class),
    .o_opcode        (w_opcode),
    .o_set_flags     (w_set_flags),
    .o_rm_imm_s      (w_rm_imm_s),
    .o_rs_imm_s      (w_rs_imm_s),
    .o_shift_op      (w_shift_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    Und_Ins       = 1'b0;
    write_pc      = 1'b0;
    write_ir      = 1'b0;
    write_reg     = 1'b0;
    LA            = 1'b0;
    LB            = 1'b0;
    LC            = 1'b0;
    LF            = 1'b0;
    pc_s          = c_PC_S_PC4;
    ALU_A_s       = 1'b0;
    ALU_B_s       = 1'b0;
    rd_s          = 1'b0;
    S_ctrl        = 1'b0;
    rm_imm_s_ctrl = 1'b0;
    rs_imm_s_ctrl = c_RS_IMM5;
    Shift_OP_ctrl = c_SHIFT_LSL;
    ALU_OP_ctrl   = c_ALU_AND;

    // Strobes stay quiet for as long as reset is held, even in FETCH.
    if (rst) begin
      w_next_state = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (W_IR_valid) begin
            write_ir     = 1'b1;
            write_pc     = 1'b1;
            pc_s         = c_PC_S_PC4;
            w_next_state = DECODE;
          end
        end

        DECODE: begin
          case (w_class)
            CLS_DP: begin
              LA           = 1'b1;
              LB           = 1'b1;
              LC           = 1'b1;
              w_next_state = EXEC;
            end
            CLS_B: begin
              w_next_state = BEXEC;
            end
            CLS_BL: begin
              LB           = 1'b1;
              w_next_state = LINK;
            end
            default: begin
              Und_Ins      = 1'b1;
              w_next_state = FETCH;
            end
          endcase
        end

        EXEC: begin
          LF            = 1'b1;
          S_ctrl        = w_set_flags;
          rm_imm_s_ctrl = w_rm_imm_s;
          rs_imm_s_ctrl = w_rs_imm_s;
          Shift_OP_ctrl = w_shift_op;
          ALU_OP_ctrl   = w_opcode;
          w_next_state  = is_test_op(w_opcode) ? FETCH : WB;
        end

        WB: begin
          write_reg    = 1'b1;
          rd_s         = 1'b0;
          w_next_state = FETCH;
        end

        LINK: begin
          ALU_OP_ctrl   = c_ALU_MOV;
          rm_imm_s_ctrl = 1'b0;
          rs_imm_s_ctrl = c_RS_IMM5;
          Shift_OP_ctrl = c_SHIFT_LSL;
          LF            = 1'b1;
          w_next_state  = LWB;
        end

        LWB: begin
          write_reg    = 1'b1;
          rd_s         = 1'b1;
          w_next_state = BEXEC;
        end

        // PC already holds fetch+4, so the target is PC+4 + (imm24<<2).
        BEXEC: begin
          ALU_A_s      = 1'b1;
          ALU_B_s      = 1'b1;
          ALU_OP_ctrl  = c_ALU_ADD;
          S_ctrl       = 1'b0;
          LF           = 1'b1;
          w_next_state = BWB;
        end

        BWB: begin
          write_pc     = 1'b1;
          pc_s         = c_PC_S_F;
          w_next_state = FETCH;
        end

        default: begin
          w_next_state = FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arm_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_arm_ctrl_fsm                                                      |
// | Scoreboard bench: per-cycle expected controls queued, monitor pops.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_arm_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] I;
  logic [31:0] IR_buf;
  logic        W_IR_valid;
  logic [3:0]  rd, rn, rm, rs;
  logic [4:0]  imm5;
  logic [11:0] imm12;
  logic [23:0] imm24;
  logic        Und_Ins, write_pc, write_ir, write_reg;
  logic        LA, LB, LC, LF;
  logic [1:0]  pc_s;
  logic        ALU_A_s, ALU_B_s, rd_s, S_ctrl, rm_imm_s_ctrl;
  logic [1:0]  rs_imm_s_ctrl;
  logic [2:0]  Shift_OP_ctrl;
  logic [3:0]  ALU_OP_ctrl;

  arm_ctrl_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .I             (I),
    .IR_buf        (IR_buf),
    .W_IR_valid    (W_IR_valid),
    .rd            (rd),
    .rn            (rn),
    .rm            (rm),
    .rs            (rs),
    .imm5          (imm5),
    .imm12         (imm12),
    .imm24         (imm24),
    .Und_Ins       (Und_Ins),
    .write_pc      (write_pc),
    .write_ir      (write_ir),
    .write_reg     (write_reg),
    .LA            (LA),
    .LB            (LB),
    .LC            (LC),
    .LF            (LF),
    .pc_s          (pc_s),
    .ALU_A_s       (ALU_A_s),
    .ALU_B_s       (ALU_B_s),
    .rd_s          (rd_s),
    .S_ctrl        (S_ctrl),
    .rm_imm_s_ctrl (rm_imm_s_ctrl),
    .rs_imm_s_ctrl (rs_imm_s_ctrl),
    .Shift_OP_ctrl (Shift_OP_ctrl),
    .ALU_OP_ctrl   (ALU_OP_ctrl)
  );

  always #5 clk = ~clk;

  // Strobe vector: {write_pc, write_ir, write_reg, LA, LB, LC, LF, Und_Ins,
  //                 S_ctrl, pc_s[1:0], ALU_A_s, ALU_B_s, rd_s}
  localparam logic [13:0] c_ST_NONE   = 14'h0000;
  localparam logic [13:0] c_ST_FETCH  = 14'h3000;
  localparam logic [13:0] c_ST_DP_DEC = 14'h0700;
  localparam logic [13:0] c_ST_EXEC   = 14'h0080;
  localparam logic [13:0] c_ST_EXEC_S = 14'h00A0;
  localparam logic [13:0] c_ST_WB     = 14'h0800;
  localparam logic [13:0] c_ST_BL_DEC = 14'h0200;
  localparam logic [13:0] c_ST_LINK   = 14'h0080;
  localparam logic [13:0] c_ST_LWB    = 14'h0801;
  localparam logic [13:0] c_ST_BEXEC  = 14'h0086;
  localparam logic [13:0] c_ST_BWB    = 14'h2010;
  localparam logic [13:0] c_ST_UND    = 14'h0040;

  typedef struct {
    string       name;
    logic [13:0] strb;
    logic [9:0]  ops_mask;
    logic [9:0]  ops;
    logic [56:0] fld;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  wire [13:0] act_strb = {write_pc, write_ir, write_reg, LA, LB, LC, LF, Und_Ins,
                          S_ctrl, pc_s, ALU_A_s, ALU_B_s, rd_s};
  // Operand controls: {rm_imm_s_ctrl, rs_imm_s_ctrl, Shift_OP_ctrl, ALU_OP_ctrl}
  wire [9:0]  act_ops  = {rm_imm_s_ctrl, rs_imm_s_ctrl, Shift_OP_ctrl, ALU_OP_ctrl};
  wire [56:0] act_fld  = {rd, rn, rm, rs, imm5, imm12, imm24};

  function automatic logic [56:0] mkfld(input logic [3:0] f_rd, input logic [3:0] f_rn,
                                        input logic [3:0] f_rm, input logic [3:0] f_rs,
                                        input logic [4:0] f_imm5, input logic [11:0] f_imm12,
                                        input logic [23:0] f_imm24);
    return {f_rd, f_rn, f_rm, f_rs, f_imm5, f_imm12, f_imm24};
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (act_strb !== e.strb) begin
        failures++;
        $display("FAIL %s strobes: got %h want %h", e.name, act_strb, e.strb);
      end
      checks++;
      if (act_fld !== e.fld) begin
        failures++;
        $display("FAIL %s fields: got %h want %h", e.name, act_fld, e.fld);
      end
      if (e.ops_mask != 10'h000) begin
        checks++;
        if ((act_ops & e.ops_mask) !== (e.ops & e.ops_mask)) begin
          failures++;
          $display("FAIL %s operand ctrl: got %h want %h (mask %h)",
                   e.name, act_ops, e.ops, e.ops_mask);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [13:0] strb, input logic [9:0] mask,
                      input logic [9:0] ops, input logic [56:0] fld);
    exp_t x;
    x.name = nm; x.strb = strb; x.ops_mask = mask; x.ops = ops; x.fld = fld;
    q.push_back(x);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expected cycles still queued", q.size());
      $fatal(1, "scoreboard stuck");
    end
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    I          = w;
    IR_buf     = w;
    W_IR_valid = 1'b1;
    @(posedge clk);
    #1;
    W_IR_valid = 1'b0;
    drain();
  endtask

  task automatic run_dp(input string nm, input logic [31:0] w, input logic [56:0] f,
                        input logic [9:0] ops, input bit s, input bit cmp);
    push({nm, ".fetch"},  c_ST_FETCH,  10'h000, 10'h000, f);
    push({nm, ".decode"}, c_ST_DP_DEC, 10'h000, 10'h000, f);
    push({nm, ".exec"},   s ? c_ST_EXEC_S : c_ST_EXEC, 10'h3FF, ops, f);
    if (!cmp) push({nm, ".wb"}, c_ST_WB, 10'h000, 10'h000, f);
    issue(w);
  endtask

  task automatic run_branch(input string nm, input logic [31:0] w, input logic [56:0] f,
                            input logic [56:0] fd, input logic [56:0] fl, input bit link);
    push({nm, ".fetch"},  c_ST_FETCH, 10'h000, 10'h000, f);
    push({nm, ".decode"}, link ? c_ST_BL_DEC : c_ST_NONE, 10'h000, 10'h000, fd);
    if (link) begin
      push({nm, ".link"}, c_ST_LINK, 10'h3FF, 10'h00D, fl);
      push({nm, ".lwb"},  c_ST_LWB,  10'h000, 10'h000, f);
    end
    push({nm, ".bexec"}, c_ST_BEXEC, 10'h00F, 10'h004, f);
    push({nm, ".bwb"},   c_ST_BWB,   10'h000, 10'h000, f);
    issue(w);
  endtask

  task automatic run_und(input string nm, input logic [31:0] w, input logic [56:0] f);
    push({nm, ".fetch"},  c_ST_FETCH, 10'h000, 10'h000, f);
    push({nm, ".decode"}, c_ST_UND,   10'h000, 10'h000, f);
    issue(w);
  endtask

  initial begin
    logic [56:0] f_add;
    f_add = mkfld(4'h1, 4'h2, 4'h3, 4'h0, 5'd0, 12'h003, 24'h821003);

    // Reset held with a valid word offered: nothing may strobe.
    rst = 1'b1; I = 32'h0; IR_buf = 32'h0; W_IR_valid = 1'b1;
    push("reset", c_ST_NONE, 10'h000, 10'h000, 57'h0);
    drain();
    rst = 1'b0; W_IR_valid = 1'b0;

    push("hold0", c_ST_NONE, 10'h000, 10'h000, 57'h0);
    push("hold1", c_ST_NONE, 10'h000, 10'h000, 57'h0);
    drain();

    run_dp("add_reg", 32'hE0821003, f_add, 10'h004, 1'b0, 1'b0);
    run_dp("adds_imm", 32'hE2911005,
           mkfld(4'h1, 4'h1, 4'h5, 4'h0, 5'd0, 12'h005, 24'h911005), 10'h364, 1'b1, 1'b0);
    run_dp("cmp", 32'hE1510002,
           mkfld(4'h0, 4'h1, 4'h2, 4'h0, 5'd0, 12'h002, 24'h510002), 10'h00A, 1'b1, 1'b1);
    run_dp("mov_lsl_reg", 32'hE1A00211,
           mkfld(4'h0, 4'h0, 4'h1, 4'h2, 5'd4, 12'h211, 24'hA00211), 10'h09D, 1'b0, 1'b0);
    run_dp("subs_asr_imm", 32'hE05431C5,
           mkfld(4'h3, 4'h4, 4'h5, 4'h1, 5'd3, 12'h1C5, 24'h5431C5), 10'h042, 1'b1, 1'b0);
    run_dp("mov_pc", 32'hE1A0F00E,
           mkfld(4'hF, 4'h0, 4'hE, 4'h0, 5'd0, 12'h00E, 24'hA0F00E), 10'h00D, 1'b0, 1'b0);
    run_dp("cmn_nos", 32'hE1600002,
           mkfld(4'h0, 4'h0, 4'h2, 4'h0, 5'd0, 12'h002, 24'h600002), 10'h00B, 1'b1, 1'b1);

    run_branch("bl_fwd", 32'hEB000002,
               mkfld(4'h0, 4'h0, 4'h2, 4'h0, 5'd0, 12'h002, 24'h000002),
               mkfld(4'h0, 4'h0, 4'hF, 4'h0, 5'd0, 12'h002, 24'h000002),
               mkfld(4'h0, 4'h0, 4'h2, 4'h0, 5'd0, 12'h002, 24'h000002), 1'b1);
    run_branch("bl_back", 32'hEBFFFF80,
               mkfld(4'hF, 4'hF, 4'h0, 4'hF, 5'd31, 12'hF80, 24'hFFFF80),
               mkfld(4'hF, 4'hF, 4'hF, 4'hF, 5'd31, 12'hF80, 24'hFFFF80),
               mkfld(4'hF, 4'hF, 4'h0, 4'hF, 5'd0,  12'hF80, 24'hFFFF80), 1'b1);
    run_branch("b", 32'hEA000F85,
               mkfld(4'h0, 4'h0, 4'h5, 4'hF, 5'd31, 12'hF85, 24'h000F85),
               mkfld(4'h0, 4'h0, 4'h5, 4'hF, 5'd31, 12'hF85, 24'h000F85),
               mkfld(4'h0, 4'h0, 4'h5, 4'hF, 5'd31, 12'hF85, 24'h000F85), 1'b0);

    run_und("und", 32'hE7F000F0,
            mkfld(4'h0, 4'h0, 4'h0, 4'h0, 5'd1, 12'h0F0, 24'hF000F0));
    run_und("mul_space", 32'hE0000090,
            mkfld(4'h0, 4'h0, 4'h0, 4'h0, 5'd1, 12'h090, 24'h000090));

    push("idle_after_und", c_ST_NONE, 10'h000, 10'h000,
         mkfld(4'h0, 4'h0, 4'h0, 4'h0, 5'd1, 12'h090, 24'h000090));
    drain();

    // Abort an ADD in EXEC: reset must silence everything at once.
    push("rst_add.fetch",  c_ST_FETCH,  10'h000, 10'h000, f_add);
    push("rst_add.decode", c_ST_DP_DEC, 10'h000, 10'h000, f_add);
    issue(32'hE0821003);
    rst = 1'b1; W_IR_valid = 1'b1;
    push("rst_mid_exec", c_ST_NONE, 10'h000, 10'h000, f_add);
    drain();
    rst = 1'b0; W_IR_valid = 1'b0;

    run_dp("add_after_rst", 32'hE0821003, f_add, 10'h004, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
